seq_timing_ctrl: RTL and testbench

- Sequence counter and decode stage for the accumulator machine.
- Sits directly upstream of the bus/control wiring block and drives its one-hot timing vector `dec_signal[15:0]` and opcode decode `dec[7:0]`.
- Tracks instruction phase from fetch through execute, decides where each instruction ends, and halts on HLT.

---
 rtl/seq_timing_ctrl.sv | 118 +++++++++++
 tb/tb_seq_timing_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_timing_ctrl.sv
// Sequence counter and opcode decode for the accumulator machine: one-hot T0..T15 timing,
// per-opcode end-of-instruction and HLT. Optional memory wait states under `SC_WAIT_EN.
module seq_timing_ctrl #(
  parameter int SC_W  = 4,
  parameter int T_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir_odat,
`ifdef SC_WAIT_EN
  input  logic        mem_rdy,
`endif
  output logic [15:0] dec_signal,
  output logic [7:0]  dec,
  output logic        ind,
  output logic        running,
  output logic        instr_done
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [SC_W-1:0] T3   = SC_W'(3);
  localparam logic [SC_W-1:0] T6   = SC_W'(6);
  localparam logic [SC_W-1:0] T8   = SC_W'(8);
  localparam logic [SC_W-1:0] T10  = SC_W'(10);
  localparam logic [SC_W-1:0] TLST = SC_W'(T_MAX);

  state_t          state, state_nx;
  logic [SC_W-1:0] sc, sc_nx;
  logic [7:0]      dec_nx;
  logic            ind_nx;
  logic            eoi;
  logic            is_hlt;
  logic            ready;
  logic            unused_ir;

  assign unused_ir = ^ir_odat[11:1];

`ifdef SC_WAIT_EN
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  // Memory slots hold the counter until the memory answers.
  assign ready = mem_rdy || !((sc == T2) || (sc == T6) || (sc == T8));
`else
  assign ready = 1'b1;
`endif

  always_comb begin
    eoi = 1'b0;
    if (dec[7])           eoi = (sc == T6);
    else if (dec[3])      eoi = (sc == T8);
    else if (|dec[2:0])   eoi = (sc == T10);
    else if (|dec[6:4])   eoi = (sc == T8);
    if (sc == TLST)       eoi = 1'b1;
  end

  assign is_hlt     = dec[7] && !ir_odat[15] && ir_odat[0] && (sc == T6);
  assign instr_done = (state == RUN) && eoi;

  always_comb begin
    state_nx = state;
    sc_nx    = sc;
    dec_nx   = dec;
    ind_nx   = ind;
    case (state)
      IDLE, HALT: begin
        dec_nx = '0;
        ind_nx = 1'b0;
        if (start) begin
          state_nx = RUN;
          sc_nx    = '0;
        end
      end
      RUN: begin
        if (ready) begin
          if (eoi) begin
            sc_nx  = '0;
            dec_nx = '0;
            ind_nx = 1'b0;
            if (is_hlt) state_nx = HALT;
          end else begin
            sc_nx = sc + SC_W'(1);
            if (sc == T3) begin
              dec_nx = 8'(1) << ir_odat[14:12];
              ind_nx = ir_odat[15];
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
        sc_nx    = '0;
        dec_nx   = '0;
        ind_nx   = 1'b0;
      end
    endcase
  end

  // Timing vector is registered from the next-state values so it lines up with sc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sc         <= '0;
      dec        <= '0;
      ind        <= 1'b0;
      dec_signal <= '0;
      running    <= 1'b0;
    end else begin
      state      <= state_nx;
      sc         <= sc_nx;
      dec        <= dec_nx;
      ind        <= ind_nx;
      dec_signal <= (state_nx == RUN) ? (16'(1) << sc_nx) : '0;
      running    <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Directed table-driven bench for seq_timing_ctrl with hand sequences for I/O, reset and stalls.
module tb_seq_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ir_odat;
`ifdef SC_WAIT_EN
  logic        mem_rdy;
`endif
  logic [15:0] dec_signal;
  logic [7:0]  dec;
  logic        ind;
  logic        running;
  logic        instr_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_timing_ctrl #(.SC_W(4), .T_MAX(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ir_odat    (ir_odat),
`ifdef SC_WAIT_EN
    .mem_rdy    (mem_rdy),
`endif
    .dec_signal (dec_signal),
    .dec        (dec),
    .ind        (ind),
    .running    (running),
    .instr_done (instr_done)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] ir;
    logic [15:0] ds;
    logic [7:0]  dec;
    logic        ind;
    logic        run;
    logic        done;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic s, input logic [15:0] ir,
                     input logic [15:0] ds, input logic [7:0] d, input logic i,
                     input logic rn, input logic dn);
    vec_t v;
    v.rst = r; v.start = s; v.ir = ir; v.ds = ds; v.dec = d; v.ind = i; v.run = rn; v.done = dn;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] ds, input logic [7:0] d,
                       input logic i, input logic rn, input logic dn);
    checks++;
    if (dec_signal !== ds || dec !== d || ind !== i || running !== rn || instr_done !== dn) begin
      failures++;
      $display("FAIL %s: got ds=%h dec=%h ind=%b run=%b done=%b, want ds=%h dec=%h ind=%b run=%b done=%b",
               name, dec_signal, dec, ind, running, instr_done, ds, d, i, rn, dn);
    end
  endtask

  task automatic apply(input string name, input logic r, input logic s, input logic [15:0] ir,
                       input logic [15:0] ds, input logic [7:0] d, input logic i,
                       input logic rn, input logic dn);
    rst = r; start = s; ir_odat = ir;
    @(posedge clk);
    #1;
    check(name, ds, d, i, rn, dn);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ir_odat = 16'h0000;
`ifdef SC_WAIT_EN
    mem_rdy = 1'b1;
`endif
    // reset, idle, start
    add(1, 0, 16'h7020, 16'h0000, 8'h00, 0, 0, 0);
    add(0, 0, 16'h7020, 16'h0000, 8'h00, 0, 0, 0);
    add(0, 1, 16'h7020, 16'h0001, 8'h00, 0, 1, 0);
    // CMA (register reference): ends at T6
    add(0, 0, 16'h7020, 16'h0002, 8'h00, 0, 1, 0);
    add(0, 0, 16'h7020, 16'h0004, 8'h00, 0, 1, 0);
    add(0, 0, 16'h7020, 16'h0008, 8'h00, 0, 1, 0);
    add(0, 0, 16'h7020, 16'h0010, 8'h80, 0, 1, 0);
    add(0, 0, 16'h7020, 16'h0020, 8'h80, 0, 1, 0);
    add(0, 0, 16'h7020, 16'h0040, 8'h80, 0, 1, 1);
    add(0, 0, 16'h7020, 16'h0001, 8'h00, 0, 1, 0);
    // opcode 2 (ALU memory op): ends at T10; start ignored while running
    add(0, 0, 16'h2005, 16'h0002, 8'h00, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0004, 8'h00, 0, 1, 0);
    add(0, 1, 16'h2005, 16'h0008, 8'h00, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0010, 8'h04, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0020, 8'h04, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0040, 8'h04, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0080, 8'h04, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0100, 8'h04, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0200, 8'h04, 0, 1, 0);
    add(0, 0, 16'h2005, 16'h0400, 8'h04, 0, 1, 1);
    add(0, 0, 16'h2005, 16'h0001, 8'h00, 0, 1, 0);
    // STA: ends at T8
    add(0, 0, 16'h3010, 16'h0002, 8'h00, 0, 1, 0);
    add(0, 0, 16'h3010, 16'h0004, 8'h00, 0, 1, 0);
    add(0, 0, 16'h3010, 16'h0008, 8'h00, 0, 1, 0);
    add(0, 0, 16'h3010, 16'h0010, 8'h08, 0, 1, 0);
    add(0, 0, 16'h3010, 16'h0020, 8'h08, 0, 1, 0);
    add(0, 0, 16'h3010, 16'h0040, 8'h08, 0, 1, 0);
    add(0, 0, 16'h3010, 16'h0080, 8'h08, 0, 1, 0);
    add(0, 0, 16'h3010, 16'h0100, 8'h08, 0, 1, 1);
    add(0, 0, 16'h3010, 16'h0001, 8'h00, 0, 1, 0);
    // HLT: halts after T6 and stays halted
    add(0, 0, 16'h7001, 16'h0002, 8'h00, 0, 1, 0);
    add(0, 0, 16'h7001, 16'h0004, 8'h00, 0, 1, 0);
    add(0, 0, 16'h7001, 16'h0008, 8'h00, 0, 1, 0);
    add(0, 0, 16'h7001, 16'h0010, 8'h80, 0, 1, 0);
    add(0, 0, 16'h7001, 16'h0020, 8'h80, 0, 1, 0);
    add(0, 0, 16'h7001, 16'h0040, 8'h80, 0, 1, 1);
    for (int i = 0; i < 11; i++)
      add(0, 0, 16'h7001, 16'h0000, 8'h00, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++)
      apply($sformatf("vec%0d", i), tv[i].rst, tv[i].start, tv[i].ir,
            tv[i].ds, tv[i].dec, tv[i].ind, tv[i].run, tv[i].done);

    // resume from HALT with an I/O instruction: ind set, bit0 does not halt
    apply("resume_t0", 0, 1, 16'hF001, 16'h0001, 8'h00, 0, 1, 0);
    apply("io_t1",     0, 0, 16'hF001, 16'h0002, 8'h00, 0, 1, 0);
    apply("io_t2",     0, 0, 16'hF001, 16'h0004, 8'h00, 0, 1, 0);
    apply("io_t3",     0, 0, 16'hF001, 16'h0008, 8'h00, 0, 1, 0);
    apply("io_t4",     0, 0, 16'hF001, 16'h0010, 8'h80, 1, 1, 0);
    apply("io_t5",     0, 0, 16'hF001, 16'h0020, 8'h80, 1, 1, 0);
    apply("io_t6",     0, 0, 16'hF001, 16'h0040, 8'h80, 1, 1, 1);
    apply("io_wrap",   0, 0, 16'hF001, 16'h0001, 8'h00, 0, 1, 0);

    // reset in the middle of an instruction at T5
    apply("mid_t1",    0, 0, 16'h2005, 16'h0002, 8'h00, 0, 1, 0);
    apply("mid_t2",    0, 0, 16'h2005, 16'h0004, 8'h00, 0, 1, 0);
    apply("mid_t3",    0, 0, 16'h2005, 16'h0008, 8'h00, 0, 1, 0);
    apply("mid_t4",    0, 0, 16'h2005, 16'h0010, 8'h04, 0, 1, 0);
    apply("mid_t5",    0, 0, 16'h2005, 16'h0020, 8'h04, 0, 1, 0);
    apply("rst_t5",    1, 0, 16'h2005, 16'h0000, 8'h00, 0, 0, 0);
    apply("idle_after",0, 0, 16'h2005, 16'h0000, 8'h00, 0, 0, 0);
    apply("restart",   0, 1, 16'h2005, 16'h0001, 8'h00, 0, 1, 0);

`ifdef SC_WAIT_EN
    // stall three cycles at T2
    apply("w_t1",      0, 0, 16'h2005, 16'h0002, 8'h00, 0, 1, 0);
    apply("w_t2",      0, 0, 16'h2005, 16'h0004, 8'h00, 0, 1, 0);
    mem_rdy = 1'b0;
    apply("w_hold1",   0, 0, 16'h2005, 16'h0004, 8'h00, 0, 1, 0);
    apply("w_hold2",   0, 0, 16'h2005, 16'h0004, 8'h00, 0, 1, 0);
    apply("w_hold3",   0, 0, 16'h2005, 16'h0004, 8'h00, 0, 1, 0);
    mem_rdy = 1'b1;
    apply("w_t3",      0, 0, 16'h2005, 16'h0008, 8'h00, 0, 1, 0);
    apply("w_t4",      0, 0, 16'h2005, 16'h0010, 8'h04, 0, 1, 0);
    apply("w_t5",      0, 0, 16'h2005, 16'h0020, 8'h04, 0, 1, 0);
    apply("w_t6",      0, 0, 16'h2005, 16'h0040, 8'h04, 0, 1, 0);
    // stall the final slot of an STA-length instruction is not reached here; reset overrides a stall
    mem_rdy = 1'b0;
    apply("w_t6_hold", 0, 0, 16'h2005, 16'h0040, 8'h04, 0, 1, 0);
    apply("w_rst",     1, 0, 16'h2005, 16'h0000, 8'h00, 0, 0, 0);
    mem_rdy = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
